bram_port_arbiter: RTL and testbench

//   Round-robin arbiter sharing one port of the dual-port feature-map BRAM between N_REQ requesters
//   (e.g. conv writer, pool reader, host loader).

---
 rtl/bram_port_arbiter.sv | 132 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between N_REQ requesters.
// Optional `BRAM_ARB_LOCK_EN adds req_lock for burst priority retention.
module bram_port_arbiter #(
  parameter int N_REQ      = 3,
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*MEM_WIDTH-1:0]  req_wdata,
`ifdef BRAM_ARB_LOCK_EN
  input  logic [N_REQ-1:0]            req_lock,
`endif
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [MEM_WIDTH-1:0]        rsp_rdata,
  output logic [ADDR_WIDTH-1:0]       bram_addr,
  output logic                        bram_ce,
  output logic                        bram_we,
  output logic [MEM_WIDTH-1:0]        bram_d,
  input  logic [MEM_WIDTH-1:0]        bram_q
);

  logic [SEL_WIDTH-1:0]  prio_q, prio_d;
  logic                  ce_q, we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [MEM_WIDTH-1:0]  d_q;
  logic                  v1_q, v2_q;
  logic [SEL_WIDTH-1:0]  idx1_q, idx2_q;

  logic                  found;
  logic [SEL_WIDTH-1:0]  gidx;
  logic [N_REQ-1:0]      grant;
  logic                  sel_we;
  logic                  sel_lock;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [MEM_WIDTH-1:0]  sel_d;
  logic [SEL_WIDTH:0]    cand;
  logic [SEL_WIDTH:0]    inc;

  // Rotating scan from prio_q; inner loop keeps all indices constant.
  always_comb begin
    found    = 1'b0;
    gidx     = '0;
    grant    = '0;
    sel_we   = 1'b0;
    sel_lock = 1'b0;
    sel_addr = '0;
    sel_d    = '0;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, prio_q} + (SEL_WIDTH+1)'(k);
      if (cand >= (SEL_WIDTH+1)'(N_REQ))
        cand = cand - (SEL_WIDTH+1)'(N_REQ);
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && reset_n && req_valid[j] &&
            cand == (SEL_WIDTH+1)'(j)) begin
          found    = 1'b1;
          gidx     = SEL_WIDTH'(j);
          grant[j] = 1'b1;
          sel_we   = req_we[j];
          sel_addr = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
          sel_d    = req_wdata[j*MEM_WIDTH +: MEM_WIDTH];
`ifdef BRAM_ARB_LOCK_EN
          sel_lock = req_lock[j];
`else
          sel_lock = 1'b0;
`endif
        end
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    inc    = {1'b0, gidx} + 1'b1;
    prio_d = prio_q;
    if (found) begin
      if (sel_lock)
        prio_d = gidx;
      else if (inc >= (SEL_WIDTH+1)'(N_REQ))
        prio_d = '0;
      else
        prio_d = inc[SEL_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= '0;
      ce_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      d_q    <= '0;
      v1_q   <= 1'b0;
      idx1_q <= '0;
      v2_q   <= 1'b0;
      idx2_q <= '0;
    end else begin
      prio_q <= prio_d;
      ce_q   <= found;
      we_q   <= found & sel_we;
      if (found) begin
        addr_q <= sel_addr;
        d_q    <= sel_d;
      end
      v1_q   <= found & ~sel_we;
      idx1_q <= gidx;
      v2_q   <= v1_q;
      idx2_q <= idx1_q;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int j = 0; j < N_REQ; j++)
      if (v2_q && idx2_q == SEL_WIDTH'(j))
        rsp_valid[j] = 1'b1;
  end

  assign rsp_rdata = bram_q;
  assign bram_addr = addr_q;
  assign bram_ce   = ce_q;
  assign bram_we   = we_q;
  assign bram_d    = d_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a 1-cycle BRAM model.
// Lock scenario runs only when BRAM_ARB_LOCK_EN is defined.
module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_we;
  logic [35:0] req_addr;
  logic [47:0] req_wdata;
`ifdef BRAM_ARB_LOCK_EN
  logic [2:0]  req_lock;
`endif
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [15:0] rsp_rdata;
  logic [11:0] bram_addr;
  logic        bram_ce;
  logic        bram_we;
  logic [15:0] bram_d;
  logic [15:0] bram_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .N_REQ(3), .ADDR_WIDTH(12), .MEM_WIDTH(16), .SEL_WIDTH(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
`ifdef BRAM_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .bram_addr(bram_addr),
    .bram_ce(bram_ce),
    .bram_we(bram_we),
    .bram_d(bram_d),
    .bram_q(bram_q)
  );

  function automatic logic [15:0] init_val(input logic [11:0] a);
    if (a == 12'h010) return 16'h1234;
    return {4'hA, a};
  endfunction

  logic [15:0]   mem [0:4095];
  logic [4095:0] wr_bm = '0;

  always @(posedge clk) begin
    if (bram_ce) begin
      if (bram_we) begin
        mem[bram_addr]   <= bram_d;
        wr_bm[bram_addr] <= 1'b1;
      end else begin
        bram_q <= wr_bm[bram_addr] ? mem[bram_addr]
                                   : init_val(bram_addr);
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic we,
                         input logic [11:0] a, input logic [15:0] d);
    req_we[i]             = we;
    req_addr[i*12 +: 12]  = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  task automatic do_reset();
    next_cyc();
    req_valid = '0;
    reset_n   = 1'b0;
    #2;
    reset_n   = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 3'b111;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
`ifdef BRAM_ARB_LOCK_EN
    req_lock  = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 3'b000) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=000", req_ready);
    end
    total++;
    if ({bram_ce, bram_we} !== 2'b00 || bram_addr !== 12'h0 ||
        bram_d !== 16'h0 || rsp_valid !== 3'b000) begin
      bad++;
      $display("FAIL reset_out got ce=%b we=%b a=%h d=%h rv=%b exp=0",
               bram_ce, bram_we, bram_addr, bram_d, rsp_valid);
    end
    req_valid = '0;
    next_cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    set_cmd(0, 1'b0, 12'h010, 16'h0);
    req_valid = 3'b001;
    @(negedge clk);
    total++;
    if (req_ready !== 3'b001) begin
      bad++;
      $display("FAIL sr_ready got=%b exp=001", req_ready);
    end
    next_cyc();
    req_valid = 3'b000;
    @(negedge clk);
    total++;
    if (bram_ce !== 1'b1 || bram_we !== 1'b0 ||
        bram_addr !== 12'h010 || rsp_valid !== 3'b000) begin
      bad++;
      $display("FAIL sr_issue got ce=%b we=%b a=%h rv=%b exp=1 0 010 000",
               bram_ce, bram_we, bram_addr, rsp_valid);
    end
    next_cyc();
    @(negedge clk);
    total++;
    if (rsp_valid !== 3'b001 || rsp_rdata !== 16'h1234) begin
      bad++;
      $display("FAIL sr_rsp got rv=%b d=%h exp=001 1234",
               rsp_valid, rsp_rdata);
    end
    total++;
    if (bram_ce !== 1'b0 || bram_addr !== 12'h010) begin
      bad++;
      $display("FAIL sr_idle got ce=%b a=%h exp=0 010",
               bram_ce, bram_addr);
    end
    next_cyc();
  endtask

  task automatic test_round_robin();
    logic [2:0] e;
    int         g;
    do_reset();
    for (int i = 0; i < 3; i++)
      set_cmd(i, 1'b0, 12'h100 + 12'(i), 16'h0);
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 6) ? 3'b111 : 3'b000;
      @(negedge clk);
      e = (k < 6) ? (3'b001 << (k % 3)) : 3'b000;
      total++;
      if (req_ready !== e) begin
        bad++;
        $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, e);
      end
      if (k >= 1 && k <= 6) begin
        g = (k - 1) % 3;
        total++;
        if (bram_ce !== 1'b1 || bram_addr !== 12'h100 + 12'(g)) begin
          bad++;
          $display("FAIL rr_issue k=%0d got ce=%b a=%h exp=1 %h",
                   k, bram_ce, bram_addr, 12'h100 + 12'(g));
        end
      end
      if (k >= 2) begin
        g = (k - 2) % 3;
        e = 3'b001 << g;
        total++;
        if (rsp_valid !== e ||
            rsp_rdata !== init_val(12'h100 + 12'(g))) begin
          bad++;
          $display("FAIL rr_rsp k=%0d got rv=%b d=%h exp=%b %h", k,
                   rsp_valid, rsp_rdata, e, init_val(12'h100 + 12'(g)));
        end
      end
      next_cyc();
    end
  endtask

  task automatic test_write_read();
    do_reset();
    set_cmd(1, 1'b1, 12'h0FF, 16'hBEEF);
    req_valid = 3'b010;
    @(negedge clk);
    total++;
    if (req_ready !== 3'b010) begin
      bad++;
      $display("FAIL wr_ready got=%b exp=010", req_ready);
    end
    next_cyc();
    set_cmd(2, 1'b0, 12'h0FF, 16'h0);
    req_valid = 3'b100;
    @(negedge clk);
    total++;
    if (req_ready !== 3'b100 || bram_ce !== 1'b1 || bram_we !== 1'b1 ||
        bram_addr !== 12'h0FF || bram_d !== 16'hBEEF) begin
      bad++;
      $display("FAIL wr_issue got rdy=%b ce=%b we=%b a=%h d=%h exp=100 1 1 0ff beef",
               req_ready, bram_ce, bram_we, bram_addr, bram_d);
    end
    next_cyc();
    req_valid = 3'b000;
    @(negedge clk);
    total++;
    if (rsp_valid !== 3'b000 || bram_we !== 1'b0 || bram_ce !== 1'b1) begin
      bad++;
      $display("FAIL wr_norsp got rv=%b we=%b ce=%b exp=000 0 1",
               rsp_valid, bram_we, bram_ce);
    end
    next_cyc();
    @(negedge clk);
    total++;
    if (rsp_valid !== 3'b100 || rsp_rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL wr_rsp got rv=%b d=%h exp=100 beef",
               rsp_valid, rsp_rdata);
    end
    next_cyc();
  endtask

  task automatic test_single_hog();
    logic [2:0] e;
    do_reset();
    set_cmd(2, 1'b0, 12'h200, 16'h0);
    set_cmd(0, 1'b0, 12'h300, 16'h0);
    for (int k = 0; k < 5; k++) begin
      req_valid = (k == 3) ? 3'b101 : 3'b100;
      e         = (k == 3) ? 3'b001 : 3'b100;
      @(negedge clk);
      total++;
      if (req_ready !== e) begin
        bad++;
        $display("FAIL hog_ready k=%0d got=%b exp=%b", k, req_ready, e);
      end
      next_cyc();
    end
    req_valid = 3'b000;
    repeat (2) next_cyc();
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_cmd(1, 1'b0, 12'h010, 16'h0);
    req_valid = 3'b010;
    @(negedge clk);
    total++;
    if (req_ready !== 3'b010) begin
      bad++;
      $display("FAIL rm_ready got=%b exp=010", req_ready);
    end
    next_cyc();
    req_valid = 3'b111;
    reset_n   = 1'b0;
    #1;
    total++;
    if (bram_ce !== 1'b0 || bram_addr !== 12'h0 ||
        rsp_valid !== 3'b000 || req_ready !== 3'b000) begin
      bad++;
      $display("FAIL rm_clear got ce=%b a=%h rv=%b rdy=%b exp=0 000 000 000",
               bram_ce, bram_addr, rsp_valid, req_ready);
    end
    req_valid = 3'b000;
    next_cyc();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 3'b000 || bram_ce !== 1'b0) begin
        bad++;
        $display("FAIL rm_drop k=%0d got rv=%b ce=%b exp=000 0",
                 k, rsp_valid, bram_ce);
      end
      next_cyc();
    end
    req_valid = 3'b111;
    @(negedge clk);
    total++;
    if (req_ready !== 3'b001) begin
      bad++;
      $display("FAIL rm_first got=%b exp=001", req_ready);
    end
    next_cyc();
    req_valid = 3'b000;
    repeat (2) next_cyc();
  endtask

`ifdef BRAM_ARB_LOCK_EN
  task automatic test_lock();
    logic [2:0] e;
    do_reset();
    set_cmd(0, 1'b0, 12'h010, 16'h0);
    set_cmd(1, 1'b0, 12'h020, 16'h0);
    req_valid = 3'b011;
    for (int k = 0; k < 6; k++) begin
      req_lock = (k < 4) ? 3'b001 : 3'b000;
      e        = (k < 5) ? 3'b001 : 3'b010;
      @(negedge clk);
      total++;
      if (req_ready !== e) begin
        bad++;
        $display("FAIL lock_ready k=%0d got=%b exp=%b", k, req_ready, e);
      end
      next_cyc();
    end
    req_valid = 3'b000;
    req_lock  = 3'b000;
    repeat (2) next_cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_read();
    test_single_hog();
    test_reset_midop();
`ifdef BRAM_ARB_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
